// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 16-bit RISC core control path.
// Holds the opcode map, the sequencer state encoding and the default
// datapath widths used by pc_sequencer and its helpers.
package cpu_ctrl_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_BEQZ  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_ERR
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter.
// Counts cycles while cnt_i is high, clears to zero on clr_i, and flags
// expired_o once the count equals MAX_WAIT (the count saturates there).
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clr_i     : synchronous clear (has priority over cnt_i)
//   cnt_i     : count one waited cycle
//   expired_o : count has reached MAX_WAIT
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic cnt_i,
  output logic expired_o
);

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (cnt_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit RISC core.
// Sole driver of the program-counter controls; also sequences the IR load,
// the memory read/write handshake and the register-file write.
//   CLK, RST_N        : clock (rising edge), asynchronous active-low reset
//   START             : pulse, leaves IDLE/HALT
//   INSTR             : instruction register, opcode in the top nibble
//   ZERO              : ALU zero flag for BEQZ
//   MEM_READY         : memory accepts the current MEM_RD/MEM_WR
//   PC_EN/PC_LD/PC_NEXT/PC_RST : PC increment, load, load value, clear
//   IR_LD             : load IR from memory data
//   MEM_RD/MEM_WR     : memory read / write request
//   ADDR_SEL          : 0 = address from PC, 1 = from INSTR target
//   RF_WE             : register-file write enable
//   HALTED / BUS_ERR  : HALT state / sticky memory timeout
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               ZERO,
  input  logic               MEM_READY,
  output logic               PC_EN,
  output logic               PC_LD,
  output logic [PC_W-1:0]    PC_NEXT,
  output logic               PC_RST,
  output logic               IR_LD,
  output logic               MEM_RD,
  output logic               MEM_WR,
  output logic               ADDR_SEL,
  output logic               RF_WE,
  output logic               HALTED,
  output logic               BUS_ERR
);

  state_e state_q, state_d;
  logic   store_q, store_d;   // MEM phase direction, captured in EXEC

  logic [3:0]      opcode;
  logic [PC_W-1:0] target;
  logic            tmr_cnt, tmr_clr, tmr_exp;
  logic            unused_instr;

  assign opcode       = INSTR[INSTR_W-1 -: 4];
  assign target       = INSTR[PC_W-1:0];
  assign unused_instr = ^INSTR;

  // Only waited FETCH/MEM cycles count; any other cycle, including the one
  // that completes the access, returns the counter to zero.
  assign tmr_clr = ~tmr_cnt;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_i     (tmr_clr),
    .cnt_i     (tmr_cnt),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    tmr_cnt  = 1'b0;
    PC_EN    = 1'b0;
    PC_LD    = 1'b0;
    PC_NEXT  = '0;
    PC_RST   = 1'b0;
    IR_LD    = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    ADDR_SEL = 1'b0;
    RF_WE    = 1'b0;
    HALTED   = 1'b0;
    BUS_ERR  = 1'b0;

    case (state_q)
      S_IDLE: begin
        PC_RST = 1'b1;
        if (START) state_d = S_FETCH;
      end

      S_FETCH: begin
        MEM_RD = 1'b1;
        // A ready on the expiry cycle still completes the fetch.
        if (MEM_READY) begin
          IR_LD   = 1'b1;
          PC_EN   = 1'b1;
          state_d = S_DECODE;
        end else if (tmr_exp) begin
          state_d = S_ERR;
        end else begin
          tmr_cnt = 1'b1;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND, OP_OR: RF_WE = 1'b1;
          OP_LOAD: begin
            store_d = 1'b0;
            state_d = S_MEM;
          end
          OP_STORE: begin
            store_d = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQZ: begin
            if (ZERO) begin
              PC_LD   = 1'b1;
              PC_NEXT = target;
            end
          end
          OP_JMP: begin
            PC_LD   = 1'b1;
            PC_NEXT = target;
          end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end

      S_MEM: begin
        ADDR_SEL = 1'b1;
        MEM_RD   = ~store_q;
        MEM_WR   = store_q;
        if (MEM_READY) begin
          RF_WE   = ~store_q;
          state_d = S_FETCH;
        end else if (tmr_exp) begin
          state_d = S_ERR;
        end else begin
          tmr_cnt = 1'b1;
        end
      end

      S_HALT: begin
        HALTED = 1'b1;
        if (START) state_d = S_IDLE;
      end

      S_ERR: BUS_ERR = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] INSTR;
  logic        ZERO;
  logic        MEM_READY;
  logic        PC_EN, PC_LD, PC_RST, IR_LD, MEM_RD, MEM_WR;
  logic        ADDR_SEL, RF_WE, HALTED, BUS_ERR;
  logic [7:0]  PC_NEXT;

  pc_sequencer #(
    .PC_W     (8),
    .INSTR_W  (16),
    .MAX_WAIT (15)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .INSTR     (INSTR),
    .ZERO      (ZERO),
    .MEM_READY (MEM_READY),
    .PC_EN     (PC_EN),
    .PC_LD     (PC_LD),
    .PC_NEXT   (PC_NEXT),
    .PC_RST    (PC_RST),
    .IR_LD     (IR_LD),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .ADDR_SEL  (ADDR_SEL),
    .RF_WE     (RF_WE),
    .HALTED    (HALTED),
    .BUS_ERR   (BUS_ERR)
  );

  always #5 CLK = ~CLK;

  // Output vector: {PC_NEXT, PC_EN, PC_LD, PC_RST, IR_LD, MEM_RD, MEM_WR,
  //                 ADDR_SEL, RF_WE, HALTED, BUS_ERR}
  localparam logic [9:0] F_EN  = 10'h200;
  localparam logic [9:0] F_LD  = 10'h100;
  localparam logic [9:0] F_RST = 10'h080;
  localparam logic [9:0] F_IR  = 10'h040;
  localparam logic [9:0] F_RD  = 10'h020;
  localparam logic [9:0] F_WR  = 10'h010;
  localparam logic [9:0] F_AS  = 10'h008;
  localparam logic [9:0] F_WE  = 10'h004;
  localparam logic [9:0] F_HLT = 10'h002;
  localparam logic [9:0] F_BE  = 10'h001;
  localparam logic [9:0] F_FOK = F_RD | F_IR | F_EN;

  logic [17:0] obs;
  assign obs = {PC_NEXT, PC_EN, PC_LD, PC_RST, IR_LD, MEM_RD, MEM_WR,
                ADDR_SEL, RF_WE, HALTED, BUS_ERR};

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [17:0] ev(input logic [7:0] nx, input logic [9:0] f);
    return {nx, f};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected for it.
  task automatic cyc(input string tag, input logic st, input logic [15:0] ins,
                     input logic z, input logic rdy, input logic [17:0] e);
    START     = st;
    INSTR     = ins;
    ZERO      = z;
    MEM_READY = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
  endtask

  // Fetch (ready at once), decode, execute for one instruction.
  task automatic run3(input string tag, input logic [15:0] ins, input logic z,
                      input logic [17:0] exec_e);
    cyc({tag, "_fetch"}, 1'b0, ins, z, 1'b1, ev(8'h00, F_FOK));
    cyc({tag, "_dec"},   1'b0, ins, z, 1'b1, ev(8'h00, 10'h000));
    cyc({tag, "_exec"},  1'b0, ins, z, 1'b1, exec_e);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [17:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(obs), 32'(e));
      chk({t, "_inv_pc"},  32'(PC_LD & PC_EN), 32'd0);
      chk({t, "_inv_mem"}, 32'(MEM_RD & MEM_WR), 32'd0);
      chk({t, "_inv_nxt"}, 32'(PC_LD ? 8'h00 : PC_NEXT), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; INSTR = '0; ZERO = 1'b0; MEM_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", 32'(obs), 32'(ev(8'h00, F_RST)));
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // ALU op: IR_LD+PC_EN cycle 1, RF_WE cycle 3, FETCH again cycle 4.
    cyc("t1_idle",  1'b1, 16'h1234, 1'b0, 1'b1, ev(8'h00, F_RST));
    cyc("t1_fetch", 1'b0, 16'h1234, 1'b0, 1'b1, ev(8'h00, F_FOK));
    cyc("t1_dec",   1'b1, 16'h1234, 1'b0, 1'b1, ev(8'h00, 10'h000)); // START ignored
    cyc("t1_exec",  1'b0, 16'h1234, 1'b0, 1'b1, ev(8'h00, F_WE));

    run3("t2_jmp",    16'h80CB, 1'b0, ev(8'hCB, F_LD));
    run3("t2_beqz_n", 16'h7029, 1'b0, ev(8'h00, 10'h000));
    run3("t2_beqz_t", 16'h7029, 1'b1, ev(8'h29, F_LD));
    run3("t2_nop",    16'h0ABC, 1'b0, ev(8'h00, 10'h000));
    run3("t2_undef",  16'hC0FE, 1'b0, ev(8'h00, 10'h000));
    run3("t2_or",     16'h4F0F, 1'b0, ev(8'h00, F_WE));

    // LOAD with three wait cycles, then STORE with one.
    run3("t3_load", 16'h5040, 1'b0, ev(8'h00, 10'h000));
    for (int i = 0; i < 3; i++)
      cyc("t3_load_wait", 1'b0, 16'h5040, 1'b0, 1'b0, ev(8'h00, F_RD | F_AS));
    cyc("t3_load_rdy", 1'b0, 16'h5040, 1'b0, 1'b1, ev(8'h00, F_RD | F_AS | F_WE));
    run3("t3_store", 16'h6041, 1'b0, ev(8'h00, 10'h000));
    cyc("t3_store_wait", 1'b0, 16'h6041, 1'b0, 1'b0, ev(8'h00, F_WR | F_AS));
    cyc("t3_store_rdy",  1'b0, 16'h6041, 1'b0, 1'b1, ev(8'h00, F_WR | F_AS));

    // Fetch waits 15 cycles; ready arrives while the count sits at 15.
    for (int i = 0; i < 15; i++)
      cyc("t4a_wait", 1'b0, 16'h2000, 1'b0, 1'b0, ev(8'h00, F_RD));
    cyc("t4a_rdy",  1'b0, 16'h2000, 1'b0, 1'b1, ev(8'h00, F_FOK));
    cyc("t4a_dec",  1'b0, 16'h2000, 1'b0, 1'b1, ev(8'h00, 10'h000));
    cyc("t4a_exec", 1'b0, 16'h2000, 1'b0, 1'b1, ev(8'h00, F_WE));

    // HALT, then START back to IDLE, then START fetches again.
    run3("t5_halt", 16'hF000, 1'b0, ev(8'h00, 10'h000));
    cyc("t5_halted",  1'b0, 16'hF000, 1'b0, 1'b1, ev(8'h00, F_HLT));
    cyc("t5_halted2", 1'b0, 16'hF000, 1'b0, 1'b1, ev(8'h00, F_HLT));
    cyc("t5_hstart",  1'b1, 16'hF000, 1'b0, 1'b1, ev(8'h00, F_HLT));
    cyc("t5_idle",    1'b0, 16'hF000, 1'b0, 1'b1, ev(8'h00, F_RST));
    cyc("t5_istart",  1'b1, 16'hF000, 1'b0, 1'b1, ev(8'h00, F_RST));
    run3("t5_refetch", 16'h3000, 1'b0, ev(8'h00, F_WE));

    // Jump to 0xFF; the following fetch increments as usual (PC wraps).
    run3("t6_jff",  16'h80FF, 1'b0, ev(8'hFF, F_LD));
    run3("t6_wrap", 16'h0000, 1'b0, ev(8'h00, 10'h000));

    // Reset asserted in the middle of a waiting STORE.
    run3("t6_store", 16'h6010, 1'b0, ev(8'h00, 10'h000));
    cyc("t6_store_wait", 1'b0, 16'h6010, 1'b0, 1'b0, ev(8'h00, F_WR | F_AS));
    MEM_READY = 1'b0;
    #2;
    chk("t6_wr_before", 32'(MEM_WR), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("t6_wr_async", 32'(MEM_WR), 32'd0);
    chk("t6_rst_vec", 32'(obs), 32'(ev(8'h00, F_RST)));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc("t6_idle", 1'b0, 16'h6010, 1'b0, 1'b1, ev(8'h00, F_RST));

    // Fetch never acknowledged: 16 waited cycles, then sticky ERR.
    cyc("t4b_idle", 1'b1, 16'h1000, 1'b0, 1'b0, ev(8'h00, F_RST));
    for (int i = 0; i < 16; i++)
      cyc("t4b_wait", 1'b0, 16'h1000, 1'b0, 1'b0, ev(8'h00, F_RD));
    for (int i = 0; i < 3; i++)
      cyc("t4b_err", 1'b1, 16'h1000, 1'b0, 1'b1, ev(8'h00, F_BE));
    RST_N = 1'b0;
    #1;
    chk("t4b_rst", 32'(obs), 32'(ev(8'h00, F_RST)));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc("t4b_after", 1'b0, 16'h1000, 1'b0, 1'b0, ev(8'h00, F_RST));

    @(negedge CLK);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
